// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the register-file write port between writeback (priority)
//            and a buffered multi-cycle unit with starvation-forced draining.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int ZERO_GUARD   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wb_valid,
  input  logic [ADDR_WIDTH-1:0]         wb_addr,
  input  logic [DATA_WIDTH-1:0]         wb_data,
  output logic                          wb_stall,
  input  logic                          mc_valid,
  output logic                          mc_ready,
  input  logic [ADDR_WIDTH-1:0]         mc_addr,
  input  logic [DATA_WIDTH-1:0]         mc_data,
  output logic                          rf_RegWrite,
  output logic [ADDR_WIDTH-1:0]         rf_write_address,
  output logic [DATA_WIDTH-1:0]         rf_write_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } starve_state_e;

  logic [ADDR_WIDTH-1:0] addr_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [3:0]            starve_q, starve_d;

  starve_state_e         starve_state;
  logic                  fifo_nonempty;
  logic                  push;
  logic                  grant_wb;
  logic                  grant_mc;
  logic                  zero_hit;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  assign fifo_nonempty = (count_q != '0);
  assign mc_ready      = (count_q < CNT_W'(FIFO_DEPTH));
  assign push          = mc_valid && mc_ready;
  assign fifo_count    = count_q;

  always_comb begin
    starve_state = ST_IDLE;
    if (fifo_nonempty) begin
      if (starve_q == 4'(STARVE_LIMIT)) starve_state = ST_FORCE;
      else                              starve_state = ST_PEND;
    end
  end

  // Grants are suppressed while reset is asserted so nothing reaches the RF.
  always_comb begin
    grant_wb = 1'b0;
    grant_mc = 1'b0;
    wb_stall = 1'b0;
    if (rst_n) begin
      if (starve_state == ST_FORCE) begin
        grant_mc = 1'b1;
        wb_stall = wb_valid;
      end else if (wb_valid) begin
        grant_wb = 1'b1;
      end else if (starve_state != ST_IDLE) begin
        grant_mc = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr         = grant_mc ? addr_mem_q[rd_ptr_q] : wb_addr;
    sel_data         = grant_mc ? data_mem_q[rd_ptr_q] : wb_data;
    zero_hit         = (ZERO_GUARD != 0) && (sel_addr == '0);
    rf_RegWrite      = (grant_wb || grant_mc) && !zero_hit;
    rf_write_address = rf_RegWrite ? sel_addr : '0;
    rf_write_data    = rf_RegWrite ? sel_data : '0;
  end

  always_comb begin
    rd_ptr_d = grant_mc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push     ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(grant_mc);
    starve_d = 4'd0;
    case (starve_state)
      ST_PEND:  starve_d = grant_mc ? 4'd0 : starve_q + 4'd1;
      default:  starve_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= 4'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= mc_addr;
      data_mem_q[wr_ptr_q] <= mc_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// Testbench for regfile_write_arbiter: directed scenarios plus random traffic
// scored against a queue-based model of the arbitration rules.
module tb_regfile_write_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_stall;
  logic          mc_valid;
  logic          mc_ready;
  logic [AW-1:0] mc_addr;
  logic [DW-1:0] mc_data;
  logic          rf_RegWrite;
  logic [AW-1:0] rf_write_address;
  logic [DW-1:0] rf_write_data;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .FIFO_DEPTH  (DEPTH),
    .STARVE_LIMIT(LIMIT),
    .ZERO_GUARD  (1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wb_valid        (wb_valid),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .wb_stall        (wb_stall),
    .mc_valid        (mc_valid),
    .mc_ready        (mc_ready),
    .mc_addr         (mc_addr),
    .mc_data         (mc_data),
    .rf_RegWrite     (rf_RegWrite),
    .rf_write_address(rf_write_address),
    .rf_write_data   (rf_write_data),
    .fifo_count      (fifo_count)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct packed {
    logic          we;
    logic          stall;
    logic          ready;
    logic [CW-1:0] cnt;
  } st_t;

  wr_t         exp_wq[$];
  st_t         exp_sq[$];
  wr_t         mq[$];
  int unsigned head_wait;
  bit          hold_wb;
  bit          hold_mc;
  bit          sb_on;
  int          checks;
  int          errors;
  st_t         mon_s;
  wr_t         mon_w;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one call per clock cycle with this cycle's inputs applied.
  task automatic model_eval();
    st_t s;
    wr_t w;
    bit  g_mc;
    bit  g_wb;
    g_mc    = 1'b0;
    g_wb    = 1'b0;
    s.ready = (mq.size() < DEPTH);
    s.cnt   = CW'(mq.size());
    s.stall = 1'b0;
    if (mq.size() > 0 && head_wait >= LIMIT) begin
      g_mc    = 1'b1;
      s.stall = wb_valid;
    end else if (wb_valid) begin
      g_wb = 1'b1;
    end else if (mq.size() > 0) begin
      g_mc = 1'b1;
    end
    if (g_mc) w = mq[0];
    else      w = {wb_addr, wb_data};
    s.we = (g_mc || g_wb) && (w.a != '0);
    exp_sq.push_back(s);
    if (s.we) exp_wq.push_back(w);
    if (g_mc) begin
      void'(mq.pop_front());
      head_wait = 0;
    end else if (mq.size() > 0) begin
      head_wait++;
    end else begin
      head_wait = 0;
    end
    hold_wb = s.stall;
    hold_mc = mc_valid && !s.ready;
    if (mc_valid && s.ready) mq.push_back({mc_addr, mc_data});
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    if (!hold_wb) begin
      wb_valid = wv;
      wb_addr  = wa;
      wb_data  = wd;
    end
    if (!hold_mc) begin
      mc_valid = mv;
      mc_addr  = ma;
      mc_data  = md;
    end
    #1;
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  always @(negedge clk) begin
    if (sb_on) begin
      if (exp_sq.size() == 0) begin
        chk("status_underflow", DW'(1), DW'(0));
      end else begin
        mon_s = exp_sq.pop_front();
        chk("wb_stall",    DW'(wb_stall),    DW'(mon_s.stall));
        chk("mc_ready",    DW'(mc_ready),    DW'(mon_s.ready));
        chk("fifo_count",  DW'(fifo_count),  DW'(mon_s.cnt));
        chk("rf_RegWrite", DW'(rf_RegWrite), DW'(mon_s.we));
      end
      if (rf_RegWrite) begin
        if (exp_wq.size() == 0) begin
          chk("unexpected_write", DW'(rf_write_address), DW'(32'hFFFF_FFFF));
        end else begin
          mon_w = exp_wq.pop_front();
          chk("rf_write_address", DW'(rf_write_address), DW'(mon_w.a));
          chk("rf_write_data",    rf_write_data,         mon_w.d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    checks    = 0;
    errors    = 0;
    sb_on     = 1'b0;
    hold_wb   = 1'b0;
    hold_mc   = 1'b0;
    head_wait = 0;
    rst_n     = 1'b0;
    wb_valid  = 1'b1;
    wb_addr   = 5'd3;
    wb_data   = 32'd30;
    mc_valid  = 1'b0;
    mc_addr   = '0;
    mc_data   = '0;

    #3;
    chk("reset_rf_RegWrite", DW'(rf_RegWrite), DW'(0));
    chk("reset_fifo_count",  DW'(fifo_count),  DW'(0));
    chk("reset_mc_ready",    DW'(mc_ready),    DW'(1));
    chk("reset_wb_stall",    DW'(wb_stall),    DW'(0));
    wb_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb_on = 1'b1;

    step(1'b1, 5'd3, 32'd30, 1'b0, '0, '0);
    idle(1);

    step(1'b0, '0, '0, 1'b1, 5'd7, 32'd70);
    idle(2);

    step(1'b1, 5'd1, 32'd100, 1'b1, 5'd9, 32'd90);
    for (int i = 0; i < 8; i++) step(1'b1, 5'(i + 2), 32'(101 + i), 1'b0, '0, '0);
    idle(2);

    step(1'b1, 5'd4, 32'd200, 1'b1, 5'd10, 32'd100);
    step(1'b1, 5'd4, 32'd201, 1'b1, 5'd11, 32'd110);
    step(1'b1, 5'd4, 32'd202, 1'b1, 5'd12, 32'd120);
    for (int i = 0; i < 14; i++) step(1'b1, 5'd5, 32'(300 + i), 1'b0, '0, '0);
    idle(4);

    step(1'b0, '0, '0, 1'b1, 5'd0, 32'd55);
    step(1'b1, 5'd0, 32'd66, 1'b0, '0, '0);
    idle(2);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) < 6,
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           32'($urandom),
           $urandom_range(0, 9) < 4,
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           32'($urandom));
    end
    idle(12);

    step(1'b1, 5'd2, 32'd20, 1'b1, 5'd13, 32'd130);
    step(1'b1, 5'd2, 32'd21, 1'b1, 5'd14, 32'd140);
    sb_on    = 1'b0;
    wb_valid = 1'b1;
    wb_addr  = 5'd2;
    wb_data  = 32'd22;
    mc_valid = 1'b0;
    #1;
    chk("pre_reset_fifo_count", DW'(fifo_count), DW'(mq.size()));
    rst_n = 1'b0;
    #1;
    chk("midreset_fifo_count",  DW'(fifo_count),  DW'(0));
    chk("midreset_rf_RegWrite", DW'(rf_RegWrite), DW'(0));
    chk("midreset_mc_ready",    DW'(mc_ready),    DW'(1));
    chk("midreset_wb_stall",    DW'(wb_stall),    DW'(0));
    chk("pre_reset_status_q",   DW'(exp_sq.size()), DW'(0));
    mq.delete();
    exp_wq.delete();
    exp_sq.delete();
    head_wait = 0;
    hold_wb   = 1'b0;
    hold_mc   = 1'b0;
    wb_valid  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sb_on = 1'b1;
    idle(6);

    chk("final_status_q", DW'(exp_sq.size()), DW'(0));
    chk("final_write_q",  DW'(exp_wq.size()), DW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the pipeline register file between two writers: the in-order writeback stage and a multi-cycle unit (divider / late load return). Writeback has priority. Multi-cycle results are buffered in a small FIFO, and a starvation counter eventually stalls writeback to drain them. The block sits between the writeback stage and the register file's `RegWrite` / `write_address` / `write_data` inputs.

## Interface
- `DATA_WIDTH`, 32, width of write data.
- `ADDR_WIDTH`, 5, register address width.
- `FIFO_DEPTH`, 2, entries in the multi-cycle result buffer (power of two, ≥2).
- `STARVE_LIMIT`, 4, cycles a non-empty FIFO head may wait before writeback is stalled (1–15).
- `ZERO_GUARD`, 1, when 1, writes to address 0 are consumed but never reach the register file.

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `wb_valid` in 1 — writeback stage has a write this cycle.
- `wb_addr` in `ADDR_WIDTH` — writeback destination.
- `wb_data` in `DATA_WIDTH` — writeback data.
- `wb_stall` out 1 — hold writeback (and upstream) this cycle; inputs must stay stable.
- `mc_valid` in 1 — multi-cycle unit offers a result.
- `mc_ready` out 1 — buffer can accept; transfer occurs when `mc_valid && mc_ready` at the edge.
- `mc_addr` in `ADDR_WIDTH` — multi-cycle destination.
- `mc_data` in `DATA_WIDTH` — multi-cycle data.
- `rf_RegWrite` out 1 — to register file `RegWrite`.
- `rf_write_address` out `ADDR_WIDTH` — to register file `write_address`.
- `rf_write_data` out `DATA_WIDTH` — to register file `write_data`.
- `fifo_count` out `clog2(FIFO_DEPTH)+1` — entries currently buffered.

## Operation
- **Buffering.** The FIFO holds {addr, data}. `mc_ready = (fifo_count < FIFO_DEPTH)`, computed from the registered count only. When the FIFO is full, a dequeue in the same cycle does not open a slot until the next cycle.
- **Arbitration.** The grant is decided combinationally each cycle.
  - If `force` is set and the FIFO is non-empty: FIFO head granted, `wb_stall = wb_valid`.
  - Else if `wb_valid`: writeback granted, `wb_stall = 0`.
  - Else if the FIFO is non-empty: FIFO head granted.
  - Else: no grant, `rf_RegWrite = 0`.
- **Dequeue.** A FIFO head is popped at the edge of any cycle in which it is granted.
- **Address-0 guard.** With `ZERO_GUARD = 1`, a granted write to address 0 still pops or completes, but `rf_RegWrite = 0`.
- **Starvation counter `starve_cnt`.** A 4-bit state register with three states.
  - IDLE (FIFO empty): counter holds 0.
  - PEND (FIFO non-empty, head not granted): counter increments.
  - FORCE (`starve_cnt == STARVE_LIMIT`): `force` is active.
  - Any FIFO grant clears the counter to 0. The next head starts counting from 0.
- **Ordering.** Order is preserved within each source only. Software/hazard logic guarantees that no wb and mc writes to the same address are outstanding together.
- **Output data.** `rf_write_address` / `rf_write_data` follow the granted source. They are don't-care when `rf_RegWrite = 0`; drive 0 for determinism.

## Timing
- **Writeback path.** Zero latency: wb inputs are muxed straight to the rf port and written at the same edge.
- **MC path.** Minimum latency is 1 cycle: accept at edge N, earliest register-file write at edge N+1.
- **Worst-case wait.** A head waits at most `STARVE_LIMIT` cycles. In the cycle after `starve_cnt` reaches the limit, it is granted.
- **Stall length.** `wb_stall` lasts exactly one cycle per forced drain. Consecutive forced grants need the counter to refill.
- **Reset (`rst_n` low, asynchronous).**
  - FIFO is emptied; `fifo_count = 0`; `starve_cnt = 0`.
  - `rf_RegWrite = 0` (gated by `rst_n` combinationally).
  - `wb_stall = 0`, `mc_ready = 1`.
  - Any in-flight FIFO entries are discarded.
- **Simultaneous events.**
  - Enqueue and dequeue in the same edge leave `fifo_count` unchanged.
  - Enqueue into an empty FIFO while `wb_valid` is high starts the counter at the next cycle.

## Test plan
- **Reset and idle.** Assert `rst_n = 0` mid-traffic with 2 entries buffered → `fifo_count = 0`, `rf_RegWrite = 0`, `mc_ready = 1` immediately; after release there are no writes.
- **Writeback pass-through.** `wb_valid = 1`, `wb_addr = 3`, `wb_data = 30`, FIFO empty → `rf_RegWrite = 1`, address 3, data 30 in the same cycle; `wb_stall = 0`.
- **Idle-slot drain.**
  - Stimulus: mc writes (7, 70) accepted at edge N, `wb_valid = 0`.
  - Required: register-file write (7, 70) at edge N+1; `fifo_count` goes 1 → 0.
- **Starvation force.**
  - Stimulus: `wb_valid` held high continuously; one mc entry (9, 90) accepted; `STARVE_LIMIT = 4`.
  - Required: wb granted for 4 cycles, then one cycle with `wb_stall = 1` and write (9, 90); wb resumes next cycle with its held data.
- **Full backpressure.**
  - Stimulus: 3 back-to-back mc offers while wb is busy.
  - Required: `mc_ready` drops after 2 accepts; the third transfers only after a pop; order is preserved (first-accepted written first).
- **Zero guard.**
  - Stimulus: mc write (0, 55), then wb write (0, 66), `ZERO_GUARD = 1`.
  - Required: both consumed (FIFO pops, no stall); `rf_RegWrite` stays 0.
